// File: rtl/io_event_packer.sv
// io_event_packer
//   Latches single-cycle button / rotary pulses into per-source pending state and
//   serialises them as one-hot event bytes into the CPU input FIFO, one write at a
//   time with at least one idle cycle between writes. Events are only coalesced
//   when a source is already pending, and each coalesced event is counted.
//   Byte format: [7]C [6]N [5]E [4]S [3]W [2]push [1]rot step [0]rot left.
//   Optional feature macro: ROTARY_ACCUM_EN (signed rotary step accumulator
//   instead of a single rotary flag plus direction register).
//   ROT_ACC_WIDTH only affects the ROTARY_ACCUM_EN build.
module io_event_packer #(
    parameter int ROT_ACC_WIDTH  = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4:0]                compass_buttons,
    input  logic                      rotary_push,
    input  logic                      rotary_event,
    input  logic                      rotary_left,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [7:0]                fifo_din,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic                      pending
);

    // Number of sources that lost an event this cycle.
    function automatic logic [2:0] count_drops(input logic [6:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 7; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Button/push flags in priority order: [0]C [1]N [2]E [3]S [4]W [5]push.
    logic [5:0]                btn_q, btn_d;
    logic [5:0]                btn_pulse_s;
    logic [5:0]                btn_clr_s;
    logic [5:0]                btn_drop_s;
    logic                      rot_pend_s;
    logic                      rot_pend_next_s;
    logic                      rot_dir_s;
    logic                      rot_clr_s;
    logic                      rot_drop_s;
    logic                      issue_s;
    logic [7:0]                byte_s;
    logic                      wr_en_q, wr_en_d;
    logic [7:0]                din_q, din_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic [DROP_CNT_WIDTH:0]   drop_sum_s;
    logic                      pend_q, pend_d;

    assign btn_pulse_s = {rotary_push, compass_buttons[4], compass_buttons[3],
                          compass_buttons[1], compass_buttons[2], compass_buttons[0]};

    // Issue decision and fixed-priority source selection.
    always_comb begin
        btn_clr_s = 6'b000000;
        rot_clr_s = 1'b0;
        byte_s    = 8'h00;
        issue_s   = ((|btn_q) || rot_pend_s) && !fifo_full && !wr_en_q;
        if (issue_s) begin
            priority casez (btn_q)
                6'b?????1: begin btn_clr_s = 6'b000001; byte_s = 8'h80; end
                6'b????10: begin btn_clr_s = 6'b000010; byte_s = 8'h40; end
                6'b???100: begin btn_clr_s = 6'b000100; byte_s = 8'h20; end
                6'b??1000: begin btn_clr_s = 6'b001000; byte_s = 8'h10; end
                6'b?10000: begin btn_clr_s = 6'b010000; byte_s = 8'h08; end
                6'b100000: begin btn_clr_s = 6'b100000; byte_s = 8'h04; end
                default:   begin rot_clr_s = 1'b1; byte_s = {6'b000000, 1'b1, rot_dir_s}; end
            endcase
        end else begin
            byte_s = 8'h00;
        end
    end

    // Button flag update: a new pulse re-arms even when its flag is being emitted.
    always_comb begin
        btn_d      = (btn_q & ~btn_clr_s) | btn_pulse_s;
        btn_drop_s = btn_pulse_s & btn_q & ~btn_clr_s;
    end

`ifdef ROTARY_ACCUM_EN
    localparam logic signed [ROT_ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ROT_ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ROT_ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ROT_ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ROT_ACC_WIDTH-1:0] ACC_ONE = {{(ROT_ACC_WIDTH-1){1'b0}}, 1'b1};

    logic signed [ROT_ACC_WIDTH-1:0] acc_q, acc_d, acc_tent_s;

    assign rot_pend_s      = (acc_q != '0);
    assign rot_dir_s       = acc_q[ROT_ACC_WIDTH-1];
    assign rot_pend_next_s = (acc_d != '0);

    // Emission moves the accumulator toward zero first; the new step is then applied
    // against that value so same-edge step and emission net out.
    always_comb begin
        acc_tent_s = acc_q;
        if (rot_clr_s) begin
            if (acc_q[ROT_ACC_WIDTH-1]) begin
                acc_tent_s = acc_q + ACC_ONE;
            end else begin
                acc_tent_s = acc_q - ACC_ONE;
            end
        end else begin
            acc_tent_s = acc_q;
        end
        acc_d      = acc_tent_s;
        rot_drop_s = 1'b0;
        if (rotary_event) begin
            if (rotary_left) begin
                if (acc_tent_s == ACC_MIN) begin
                    rot_drop_s = 1'b1;
                end else begin
                    acc_d = acc_tent_s - ACC_ONE;
                end
            end else begin
                if (acc_tent_s == ACC_MAX) begin
                    rot_drop_s = 1'b1;
                end else begin
                    acc_d = acc_tent_s + ACC_ONE;
                end
            end
        end else begin
            acc_d = acc_tent_s;
        end
    end

    // Rotary accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic rot_q, rot_d;
    logic dir_q, dir_d;

    assign rot_pend_s      = rot_q;
    assign rot_dir_s       = dir_q;
    assign rot_pend_next_s = rot_d;

    // Single rotary flag; the latest step always decides the direction.
    always_comb begin
        rot_d      = (rot_q & ~rot_clr_s) | rotary_event;
        rot_drop_s = rotary_event & rot_q & ~rot_clr_s;
        if (rotary_event) begin
            dir_d = rotary_left;
        end else begin
            dir_d = dir_q;
        end
    end

    // Rotary flag and direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
            dir_q <= dir_d;
        end
    end
`endif

    // Output next-state: write strobe, byte, saturating drop counter, pending summary.
    always_comb begin
        wr_en_d    = issue_s;
        din_d      = byte_s;
        drop_sum_s = {1'b0, drop_q} +
                     (DROP_CNT_WIDTH+1)'(count_drops({btn_drop_s, rot_drop_s}));
        if (drop_sum_s[DROP_CNT_WIDTH]) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum_s[DROP_CNT_WIDTH-1:0];
        end
        pend_d = (|btn_d) || rot_pend_next_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q   <= 6'b000000;
            wr_en_q <= 1'b0;
            din_q   <= 8'h00;
            drop_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            btn_q   <= btn_d;
            wr_en_q <= wr_en_d;
            din_q   <= din_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
        end
    end

    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;
    assign drop_count = drop_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_io_event_packer.sv
// Testbench for io_event_packer: table of single-source events plus hand-written
// multi-cycle sequences; every FIFO write is checked against a scoreboard queue.
module tb_io_event_packer;

    logic       clk;
    logic       rst_n;
    logic [4:0] compass_buttons;
    logic       rotary_push;
    logic       rotary_event;
    logic       rotary_left;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_din;
    logic [7:0] drop_count;
    logic       pending;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       prev_wr;

    typedef struct packed {
        logic [4:0] btn;
        logic       push;
        logic       ev;
        logic       left;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[8];

    io_event_packer #(.ROT_ACC_WIDTH(4), .DROP_CNT_WIDTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .compass_buttons (compass_buttons),
        .rotary_push     (rotary_push),
        .rotary_event    (rotary_event),
        .rotary_left     (rotary_left),
        .fifo_full       (fifo_full),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_din        (fifo_din),
        .drop_count      (drop_count),
        .pending         (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] b, input logic p, input logic e, input logic l);
        compass_buttons = b;
        rotary_push     = p;
        rotary_event    = e;
        rotary_left     = l;
        tick();
        compass_buttons = 5'b00000;
        rotary_push     = 1'b0;
        rotary_event    = 1'b0;
        rotary_left     = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            tick();
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        compass_buttons = 5'b00000;
        rotary_push     = 1'b0;
        rotary_event    = 1'b0;
        rotary_left     = 1'b0;
        fifo_full       = 1'b0;
        tick();
        tick();
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_pending", pending, 0);
        rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: every write must match the next expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_wr_en) begin
                if (prev_wr) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL back_to_back_write: din=%0h", fifo_din);
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got %0h expected no write", fifo_din);
                end else begin
                    chk("write_byte", fifo_din, exp_q.pop_front());
                end
            end else begin
                chk("idle_din", fifo_din, 0);
            end
        end
        prev_wr <= fifo_wr_en & rst_n;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{btn: 5'b00001, push: 1'b0, ev: 1'b0, left: 1'b0, exp_byte: 8'h80};
        vecs[1] = '{btn: 5'b00010, push: 1'b0, ev: 1'b0, left: 1'b0, exp_byte: 8'h20};
        vecs[2] = '{btn: 5'b00100, push: 1'b0, ev: 1'b0, left: 1'b0, exp_byte: 8'h40};
        vecs[3] = '{btn: 5'b01000, push: 1'b0, ev: 1'b0, left: 1'b0, exp_byte: 8'h10};
        vecs[4] = '{btn: 5'b10000, push: 1'b0, ev: 1'b0, left: 1'b0, exp_byte: 8'h08};
        vecs[5] = '{btn: 5'b00000, push: 1'b1, ev: 1'b0, left: 1'b0, exp_byte: 8'h04};
        vecs[6] = '{btn: 5'b00000, push: 1'b0, ev: 1'b1, left: 1'b0, exp_byte: 8'h02};
        vecs[7] = '{btn: 5'b00000, push: 1'b0, ev: 1'b1, left: 1'b1, exp_byte: 8'h03};

        prev_wr = 1'b0;
        do_reset();

        // Table: each source alone produces its one-hot byte.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(vecs[i].exp_byte);
            pulse(vecs[i].btn, vecs[i].push, vecs[i].ev, vecs[i].left);
            drain("table_drain");
            chk("table_pending_after", pending, 0);
        end
        chk("table_drop", drop_count, 0);

        // Latency: N pulse captured at edge k, written at edge k+1 for one cycle.
        do_reset();
        exp_q.push_back(8'h40);
        pulse(5'b00100, 1'b0, 1'b0, 1'b0);
        chk("lat_no_early_write", fifo_wr_en, 0);
        chk("lat_pending", pending, 1);
        tick();
        chk("lat_wr_en", fifo_wr_en, 1);
        chk("lat_din", fifo_din, 8'h40);
        tick();
        chk("lat_one_cycle", fifo_wr_en, 0);
        drain("lat_drain");

        // C and W together: 80 then 08 two cycles apart, no drops.
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h08);
        pulse(5'b10001, 1'b0, 1'b0, 1'b0);
        tick();
        chk("cw_first", fifo_din, 8'h80);
        tick();
        chk("cw_gap", fifo_wr_en, 0);
        tick();
        chk("cw_second_en", fifo_wr_en, 1);
        chk("cw_second", fifo_din, 8'h08);
        drain("cw_drain");
        chk("cw_drop", drop_count, 0);

        // Set wins over clear: N held across its own emission edge re-arms, no drop.
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h40);
        compass_buttons = 5'b00100;
        tick();
        tick();
        compass_buttons = 5'b00000;
        drain("rearm_drain");
        chk("rearm_drop", drop_count, 0);

        // FIFO full: two N pulses coalesce into one write and one drop.
        do_reset();
        fifo_full = 1'b1;
        pulse(5'b00100, 1'b0, 1'b0, 1'b0);
        pulse(5'b00100, 1'b0, 1'b0, 1'b0);
        tick();
        chk("full_no_write", fifo_wr_en, 0);
        exp_q.push_back(8'h40);
        fifo_full = 1'b0;
        drain("full_drain");
        chk("full_drop", drop_count, 1);

`ifdef ROTARY_ACCUM_EN
        // Accumulator: 10 right steps saturate at +7, 3 dropped, 7 writes of 02.
        do_reset();
        fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pulse(5'b00000, 1'b0, 1'b1, 1'b0);
        end
        chk("acc_drop", drop_count, 3);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(8'h02);
        end
        fifo_full = 1'b0;
        drain("acc_drain");
        chk("acc_pending_after", pending, 0);
        chk("acc_drop_after", drop_count, 3);
`else
        // Single rotary flag: right then left while full -> one 03, one drop.
        do_reset();
        fifo_full = 1'b1;
        pulse(5'b00000, 1'b0, 1'b1, 1'b0);
        pulse(5'b00000, 1'b0, 1'b1, 1'b1);
        chk("rot_drop", drop_count, 1);
        exp_q.push_back(8'h03);
        fifo_full = 1'b0;
        drain("rot_drain");
        chk("rot_pending_after", pending, 0);
`endif

        // Async reset mid-operation: write in flight is killed, nothing follows.
        do_reset();
        pulse(5'b00100, 1'b0, 1'b1, 1'b0);
        tick();
        chk("mid_rst_write_before", fifo_wr_en, 1);
        chk("mid_rst_din_before", fifo_din, 8'h40);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", fifo_wr_en, 0);
        chk("mid_rst_din", fifo_din, 0);
        chk("mid_rst_pending", pending, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk("mid_rst_pending_after", pending, 0);
        chk("mid_rst_drop", drop_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
